// File: rtl/hilo_muldiv.sv
// hilo_muldiv: iterative multiply/divide unit owning the HI/LO registers.
//   One bit per cycle shift-add multiply (MULT/MULTU/MADD/MSUB) and restoring
//   divide (DIV/DIVU), plus MTHI/MTLO direct writes.
//   Optional divider: define HILO_MULDIV_DIV_EN to build it; when undefined,
//   DIV/DIVU complete in two cycles without touching Hi/Lo.
// Ports:
//   Clk, Reset (async, active low)
//   Start, Op[2:0], A, B   - request, sampled only in IDLE
//   Busy, Done, DivByZero  - handshake / status
//   Hi, Lo                 - architectural registers (always registered)
module hilo_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             DivByZero
);
  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
`ifdef HILO_MULDIV_DIV_EN
    S_DIV,
`endif
    S_FIX,
    S_DONE
  } state_t;

  state_t           state, state_n;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] mcand;    // multiplicand or divisor magnitude
  logic [W2-1:0]    prod;     // product, or {remainder, quotient} when dividing
  logic [CW-1:0]    cnt;
  logic             neg_q;    // negate product / quotient in FIX
`ifdef HILO_MULDIV_DIV_EN
  logic             neg_r;    // negate remainder in FIX
  logic             dz;
`endif

  logic             accept, is_mul, is_div, signed_op;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [W2-1:0]    prod_s, mul_res;

  always_comb begin
    accept    = (state == S_IDLE) && Start;
    is_mul    = ~Op[2];
    is_div    = (Op[2:1] == 2'b10);
    signed_op = is_mul ? (Op != 3'b001) : (Op == 3'b100);
    a_mag     = (signed_op && A[WIDTH-1]) ? -A : A;
    b_mag     = (signed_op && B[WIDTH-1]) ? -B : B;
    // Add multiplicand into the upper half when the current LSB is set; the
    // carry becomes the new MSB after the right shift.
    mul_sum   = {1'b0, prod[W2-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    prod_s    = neg_q ? -prod : prod;
    case (op_q)
      3'b010:  mul_res = {Hi, Lo} + prod_s;
      3'b011:  mul_res = {Hi, Lo} - prod_s;
      default: mul_res = prod_s;
    endcase
  end

`ifdef HILO_MULDIV_DIV_EN
  logic [WIDTH:0]   div_tmp;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;
  always_comb begin
    // Partial remainder shifted left with the next dividend bit. Its top bit
    // set means it already exceeds any WIDTH-bit divisor.
    div_tmp = {prod[W2-1:WIDTH], prod[WIDTH-1]};
    div_ge  = div_tmp[WIDTH] || (div_tmp[WIDTH-1:0] >= mcand);
    div_rem = div_ge ? (div_tmp[WIDTH-1:0] - mcand) : div_tmp[WIDTH-1:0];
  end
`endif

  // State register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next state
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (Start) begin
        if (is_mul) state_n = S_MUL;
`ifdef HILO_MULDIV_DIV_EN
        else if (is_div) state_n = (B == '0) ? S_FIX : S_DIV;
`else
        else if (is_div) state_n = S_FIX;
`endif
      end
      S_MUL:  if (cnt == CW'(1)) state_n = S_FIX;
`ifdef HILO_MULDIV_DIV_EN
      S_DIV:  if (cnt == CW'(1)) state_n = S_FIX;
`endif
      S_FIX:  state_n = S_DONE;
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    Busy = (state == S_MUL) || (state == S_FIX);
`ifdef HILO_MULDIV_DIV_EN
    Busy = Busy || (state == S_DIV);
    DivByZero = (state == S_DONE) && dz;
`else
    DivByZero = 1'b0;
`endif
    Done = (state == S_DONE);
  end

  // Datapath and HI/LO
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Hi    <= '0;
      Lo    <= '0;
      op_q  <= '0;
      mcand <= '0;
      prod  <= '0;
      cnt   <= '0;
      neg_q <= 1'b0;
`ifdef HILO_MULDIV_DIV_EN
      neg_r <= 1'b0;
      dz    <= 1'b0;
`endif
    end else begin
      if (accept) begin
        op_q  <= Op;
        mcand <= b_mag;
        cnt   <= CW'(WIDTH);
        prod  <= {{WIDTH{1'b0}}, a_mag};
        neg_q <= signed_op && (A[WIDTH-1] ^ B[WIDTH-1]);
`ifdef HILO_MULDIV_DIV_EN
        neg_r <= signed_op && A[WIDTH-1];
        dz    <= is_div && (B == '0);
        // Divide by zero preloads the final {Hi, Lo} and skips the iterations.
        if (is_div && (B == '0)) begin
          prod  <= {A, {WIDTH{1'b1}}};
          neg_q <= 1'b0;
          neg_r <= 1'b0;
        end
`endif
        if (Op == 3'b110) Hi <= A;
        if (Op == 3'b111) Lo <= A;
      end
      case (state)
        S_MUL: begin
          prod <= {mul_sum, prod[WIDTH-1:1]};
          cnt  <= cnt - CW'(1);
        end
`ifdef HILO_MULDIV_DIV_EN
        S_DIV: begin
          prod <= {div_rem, prod[WIDTH-2:0], div_ge};
          cnt  <= cnt - CW'(1);
        end
`endif
        S_FIX: begin
          if (!op_q[2]) begin
            {Hi, Lo} <= mul_res;
          end
`ifdef HILO_MULDIV_DIV_EN
          else begin
            Hi <= neg_r ? -prod[W2-1:WIDTH] : prod[W2-1:WIDTH];
            Lo <= neg_q ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
          end
`endif
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_hilo_muldiv.sv
// Scoreboard bench for hilo_muldiv (WIDTH=32). Stimulus pushes the expected
// {Hi, Lo, DivByZero, Done cycle} per operation; a monitor pops on Done.
module tb_hilo_muldiv;
`ifdef HILO_MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, dbz;
  logic [31:0] hi, lo;

  hilo_muldiv #(.WIDTH(32)) dut (
    .Clk(clk), .Reset(rst_n), .Start(start), .Op(op), .A(a), .B(b),
    .Busy(busy), .Done(done), .Hi(hi), .Lo(lo), .DivByZero(dbz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   acc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc - acc);
    end
  endtask

  // Monitor: every Done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: Done with empty scoreboard at cycle %0d", cyc - acc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("hi", {32'h0, hi}, {32'h0, e.hi});
        chk("lo", {32'h0, lo}, {32'h0, e.lo});
        chk("divbyzero", {63'h0, dbz}, {63'h0, e.dz});
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
        chk("busy_in_done", {63'h0, busy}, 64'h0);
      end
    end
  end

  // Present a request for one cycle; acc is cycle 0 (the accept edge).
  task automatic issue(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv;
    acc = cyc;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic expect_res(input logic [31:0] h, input logic [31:0] l, input logic d, input int lat);
    sb.push_back('{h, l, d, acc + lat});
  endtask

  task automatic wait_cycle(input int k);
    while (cyc - acc < k) @(negedge clk);
  endtask

  // Wait for Done (bounded), then confirm it is a single-cycle pulse.
  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: no Done within %0d cycles", n);
    end
    @(negedge clk);
    chk("done_pulse", {63'h0, done}, 64'h0);
    chk("dz_after_done", {63'h0, dbz}, 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", {63'h0, busy}, 64'h0);
    chk("rst_done", {63'h0, done}, 64'h0);
    chk("rst_hilo", {hi, lo}, 64'h0);
    rst_n = 1'b1;

    // MULT -3 * 7
    issue(3'b000, 32'hFFFF_FFFD, 32'd7);
    expect_res(32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 34);
    wait_cycle(1);
    chk("mult_busy_c1", {63'h0, busy}, 64'h1);
    wait_cycle(33);
    chk("mult_busy_c33", {63'h0, busy}, 64'h1);
    chk("mult_hold_c33", {hi, lo}, 64'h0);
    wait_done();

    // MULTU max*max, with a stray Start in cycle 5 that must be ignored
    issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    expect_res(32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 34);
    wait_cycle(5);
    start = 1'b1; op = 3'b111; a = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done();

    // MTHI / MTLO: immediate, no Busy/Done
    issue(3'b110, 32'h0, 32'h0);
    chk("mthi_hi", {32'h0, hi}, 64'h0);
    chk("mthi_busy", {62'h0, busy, done}, 64'h0);
    issue(3'b111, 32'd5, 32'h0);
    chk("mtlo_lo", {32'h0, lo}, 64'h5);

    // MADD 2*3 then MSUB 4*4
    issue(3'b010, 32'd2, 32'd3);
    expect_res(32'h0, 32'h0000_000B, 1'b0, 34);
    wait_done();
    issue(3'b011, 32'd4, 32'd4);
    expect_res(32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b0, 34);
    wait_done();

    // MULT most-negative squared = 2^62
    issue(3'b000, 32'h8000_0000, 32'h8000_0000);
    expect_res(32'h4000_0000, 32'h0, 1'b0, 34);
    wait_done();

    // Divides: without the divider Hi/Lo stay {0x40000000, 0}
    issue(3'b100, 32'hFFFF_FFF9, 32'd2);
    expect_res(DIV_EN ? 32'hFFFF_FFFF : 32'h4000_0000,
               DIV_EN ? 32'hFFFF_FFFD : 32'h0, 1'b0, DIV_EN ? 34 : 2);
    wait_done();
    issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
    expect_res(DIV_EN ? 32'h0 : 32'h4000_0000,
               DIV_EN ? 32'h8000_0000 : 32'h0, 1'b0, DIV_EN ? 34 : 2);
    wait_done();
    issue(3'b101, 32'd100, 32'd7);
    expect_res(DIV_EN ? 32'd2 : 32'h4000_0000,
               DIV_EN ? 32'd14 : 32'h0, 1'b0, DIV_EN ? 34 : 2);
    wait_done();

    // DIVU 9/0
    issue(3'b101, 32'd9, 32'd0);
    expect_res(DIV_EN ? 32'd9 : 32'h4000_0000,
               DIV_EN ? 32'hFFFF_FFFF : 32'h0, DIV_EN, 2);
    wait_cycle(1);
    chk("div0_busy_c1", {63'h0, busy}, 64'h1);
    wait_done();

    // Reset in cycle 10 of a MULT: outputs clear without a clock edge
    issue(3'b000, 32'd5, 32'd6);
    chk("pre_rst_hilo_nonzero", {63'h0, ({hi, lo} != 64'h0)}, 64'h1);
    wait_cycle(10);
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", {62'h0, busy, done}, 64'h0);
    chk("async_rst_hilo", {hi, lo}, 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    issue(3'b000, 32'd3, 32'd4);
    expect_res(32'h0, 32'd12, 1'b0, 34);
    wait_done();

    repeat (5) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hilo_muldiv.md
# hilo_muldiv

Multi-cycle, parametrised multiply/divide unit that owns the architectural HI/LO registers for the MIPS datapath. It sits beside the combinational ALU in EX and takes MULT/MULTU/MADD/MSUB/DIV/DIVU/MTHI/MTLO from the decoder. It computes iteratively, one bit per cycle, under a Start/Busy/Done handshake that the hazard unit uses to stall mfhi/mflo. Hi/Lo are always driven from registers, never combinationally.

## Interface
- WIDTH, 32: operand width and width of each of Hi and Lo; must be even and ≥ 8.
- Clk  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low.
- Start  in  1  request; sampled only in IDLE.
- Op  in  3  operation: 000 MULT, 001 MULTU, 010 MADD, 011 MSUB, 100 DIV, 101 DIVU, 110 MTHI, 111 MTLO.
- A  in  WIDTH  rs operand (dividend).
- B  in  WIDTH  rt operand (divisor).
- Busy  out  1  high in MUL, DIV, FIX.
- Done  out  1  one-cycle pulse in DONE.
- Hi  out  WIDTH  HI register.
- Lo  out  WIDTH  LO register.
- DivByZero  out  1  high only during the DONE cycle of a DIV/DIVU with B==0.

## Operation
- States: IDLE, MUL, DIV, FIX, DONE.
- Accept: IDLE & Start latches Op, operand magnitudes (signed ops) or raw values (unsigned ops), and result-sign flags.
- MTHI/MTLO: Hi (or Lo) ← A at the accept edge. The FSM stays in IDLE; Busy and Done stay 0.
- MUL path: MULT/MULTU/MADD/MSUB go to MUL. Shift-add runs WIDTH iterations on the 2·WIDTH product register, tracked by a log2(WIDTH)+1-bit counter. Then FIX.
- FIX for multiply:
  - Negate the product if the sign flag is set.
  - MADD: {Hi,Lo} ← {Hi,Lo} + product.
  - MSUB: {Hi,Lo} ← {Hi,Lo} − product.
  - MULT/MULTU: {Hi,Lo} ← product.
  - All arithmetic is mod 2^(2·WIDTH).
  - MADD/MSUB use the signed product.
- DIV path:
  - Restoring division, WIDTH iterations, then FIX.
  - Quotient goes to Lo. Its sign is sign(A)^sign(B).
  - Remainder goes to Hi. Its sign follows A.
  - Most-negative / −1 gives Lo = 1 followed by WIDTH−1 zeros, Hi = 0. There is no trap.
- Divide by zero (B==0):
  - Skip the iterations: IDLE → FIX → DONE.
  - Hi ← A, Lo ← all ones.
  - DivByZero=1 in the DONE cycle.
- DONE: Done=1 for exactly one cycle, then IDLE. Start is not sampled in DONE.
- Start while Busy or Done is high is ignored; no queueing.
- Reset low, at any time including mid-operation:
  - State → IDLE.
  - Hi, Lo → 0; Busy, Done, DivByZero → 0.
  - Any in-flight operation is discarded.

## Timing
- Accept edge = cycle 0.
- MUL/DIV: Busy in cycles 1..WIDTH+1. Hi/Lo are written at the end of cycle WIDTH+1 (FIX). Done and the valid result appear in cycle WIDTH+2 (34 for WIDTH=32).
- Divide by zero: Busy in cycle 1, Done in cycle 2.
- MTHI/MTLO: Hi/Lo show the new value from cycle 1.
- Next Start can be accepted in cycle WIDTH+3 (or cycle 3 for divide by zero).
- Hi/Lo hold their value throughout Busy; they change only at the FIX edge or an MTHI/MTLO edge.

## Configuration
- HILO_MULDIV_DIV_EN defined: the divider and the DIV state are built as described.
- HILO_MULDIV_DIV_EN undefined:
  - No divider logic is built and the DIV state is removed.
  - DIV/DIVU go IDLE → FIX → DONE with Hi/Lo unchanged.
  - Done pulses in cycle 2; DivByZero stays tied to 0.

## Test plan
- Signed multiply: MULT A=0xFFFFFFFD (−3), B=7 → Busy in cycles 1–33, Done in cycle 34, Hi=0xFFFFFFFF, Lo=0xFFFFFFEB.
- Unsigned multiply: MULTU A=B=0xFFFFFFFF → Hi=0xFFFFFFFE, Lo=0x00000001; Start pulsed in cycle 5 is ignored.
- Accumulate: MTHI 0, MTLO 5, then MADD 2×3 → Hi=0, Lo=0x0000000B. Then MSUB 4×4 → Hi=0xFFFFFFFF, Lo=0xFFFFFFFB.
- Signed divide (with macro): DIV −7/2 → Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF → Lo=0x80000000, Hi=0.
- Divide by zero and macro off:
  - With macro: DIVU 9/0 → Done in cycle 2, DivByZero=1 for that cycle only, Hi=9, Lo=0xFFFFFFFF.
  - Without macro: same stimulus → Done in cycle 2, Hi/Lo unchanged, DivByZero=0.
- Reset mid-operation: MULT started, Reset driven low in cycle 10 → Busy=Done=0 and Hi=Lo=0 immediately, without waiting for a clock edge. After release, a new MULT 3×4 gives Lo=12 in cycle 34.
